// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and helpers for the iterative divider.
//   div_state_t : handshake FSM states (IDLE, CALC, DONE)
//   abs_val     : magnitude of a sign-extended operand, MAX_W bits wide
package seq_divider_pkg;

  // Widest operand the helper handles; callers sign-extend into it and
  // size-cast the result back down to their own width.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // |x| for two's-complement x when is_signed, x unchanged otherwise.
  // |MIN| wraps to 2^(W-1), which is exactly the unsigned magnitude wanted
  // once truncated back to W bits.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                               input logic             is_signed);
    return (is_signed && x[MAX_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/divu_core.sv
// divu_core: unsigned restoring radix-2 divider, one quotient bit per clock.
//   clk_i, rst_i : clock, async active-high reset
//   start_i      : one-cycle pulse, loads num_i / den_i and clears the counter
//   num_i, den_i : dividend / divisor magnitudes
//   done_o       : high once all WIDTH iterations are complete
//   quo_o, rem_o : quotient / remainder magnitudes (valid while done_o)
module divu_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] num_i,
  input  logic [WIDTH-1:0] den_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;  // settled remainder is always < divisor
  logic [WIDTH-1:0] quo_q,  quo_d;   // numerator bits shift out, quotient bits shift in
  logic [WIDTH-1:0] den_q,  den_d;
  logic [WIDTH:0]   shifted, diff;   // WIDTH+1-bit working partial remainder

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    shifted = {prem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, den_q};
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      prem_d = '0;
      quo_d  = num_i;
      den_d  = den_i;
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        // diff[WIDTH] is the borrow: restore (keep shifted) when it is set.
        prem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      prem_q <= '0;
      quo_q  <= '0;
      den_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      prem_q <= prem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign quo_o  = quo_q;
  assign rem_o  = prem_q;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative signed/unsigned integer divider with valid/ready
// handshakes on operand and result sides.
//   clk_i, rst_i                        : clock, async active-high reset
//   valid_i, ready_o                    : operand handshake (ready_o = IDLE)
//   signed_i, numerator_i, denominator_i: operands, sampled at accept
//   valid_o, ready_i                    : result handshake (valid_o = DONE)
//   quotient_o, remainder_o             : registered result
//   div_by_zero_o, overflow_o           : registered special-case flags
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] numerator_i,
  input  logic [WIDTH-1:0] denominator_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);
  import seq_divider_pkg::*;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic             spc_q, spc_d;          // special case: skip the datapath
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             is_dbz, is_ovf;
  logic [WIDTH-1:0] num_mag, den_mag;
  logic             core_start, core_done;
  logic [WIDTH-1:0] core_quo, core_rem;

  assign is_dbz  = (denominator_i == '0);
  assign is_ovf  = signed_i && (numerator_i == MIN_VAL) && (denominator_i == '1);
  assign num_mag = WIDTH'(abs_val(MAX_W'($signed(numerator_i)), signed_i));
  assign den_mag = WIDTH'(abs_val(MAX_W'($signed(denominator_i)), signed_i));

  divu_core #(.WIDTH(WIDTH)) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (core_start),
    .num_i   (num_mag),
    .den_i   (den_mag),
    .done_o  (core_done),
    .quo_o   (core_quo),
    .rem_o   (core_rem)
  );

  always_comb begin
    state_d     = state_q;
    spc_d       = spc_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    core_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          // Every accept passes through CALC so special cases still see one
          // cycle of latency; their result is loaded here while valid_o is
          // low, so CALC only has to wait a single edge before DONE.
          state_d    = CALC;
          spc_d      = is_dbz || is_ovf;
          quo_neg_d  = signed_i && (numerator_i[WIDTH-1] ^ denominator_i[WIDTH-1]);
          rem_neg_d  = signed_i && numerator_i[WIDTH-1];
          core_start = !(is_dbz || is_ovf);
          if (is_dbz) begin
            quotient_d  = '1;
            remainder_d = numerator_i;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
          end else if (is_ovf) begin
            quotient_d  = MIN_VAL;
            remainder_d = '0;
            dbz_d       = 1'b0;
            ovf_d       = 1'b1;
          end
        end
      end
      CALC: begin
        if (spc_q) begin
          state_d = DONE;
        end else if (core_done) begin
          state_d     = DONE;
          quotient_d  = quo_neg_q ? -core_quo : core_quo;
          remainder_d = rem_neg_q ? -core_rem : core_rem;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      spc_q       <= 1'b0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      spc_q       <= spc_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign valid_o       = (state_q == DONE);
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table, reset/backpressure sequences and random
// vectors checked against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_i, valid_i, signed_i, ready_i;
  logic [W-1:0] numerator_i, denominator_i;
  logic         ready_o, valid_o, div_by_zero_o, overflow_o;
  logic [W-1:0] quotient_o, remainder_o;

  int n_vec = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .signed_i      (signed_i),
    .numerator_i   (numerator_i),
    .denominator_i (denominator_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] n, d, q, r;
    logic         dz, ov;
    int           lat;
    int           bp;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: C truncating division plus the defined special cases.
  function automatic void ref_div(input logic sgn, input logic [W-1:0] n, d,
                                  output logic [W-1:0] q, r, output logic dz, ov);
    longint sn, sd;
    dz = 1'b0;
    ov = 1'b0;
    if (d == '0) begin
      q  = '1;
      r  = n;
      dz = 1'b1;
    end else if (!sgn) begin
      q = n / d;
      r = n % d;
    end else begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      if (sn == -(longint'(1) << (W - 1)) && sd == -1) begin
        q  = n;
        r  = '0;
        ov = 1'b1;
      end else begin
        q = W'(sn / sd);
        r = W'(sn % sd);
      end
    end
  endfunction

  // One complete transaction; bp cycles of result backpressure during which
  // fresh operands are offered and must be ignored.
  task automatic txn(input logic sgn, input logic [W-1:0] n, d, input int bp,
                     output logic [W-1:0] q, r, output logic dz, ov, output int lat);
    int   t;
    logic busy_bad, stable_bad;
    t = 0;
    while (!ready_o && t < 50) begin tick(); t++; end
    chk("accept_ready", ready_o, 1);
    signed_i = sgn; numerator_i = n; denominator_i = d; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    numerator_i = W'($urandom); denominator_i = W'($urandom); signed_i = 1'($urandom);
    lat = 0; busy_bad = 1'b0;
    while (!valid_o && lat < W + 8) begin
      if (ready_o) busy_bad = 1'b1;
      tick();
      lat++;
    end
    chk("ready_low_busy", busy_bad, 0);
    q = quotient_o; r = remainder_o; dz = div_by_zero_o; ov = overflow_o;
    stable_bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      valid_i = 1'b1; signed_i = 1'($urandom);
      numerator_i = W'($urandom); denominator_i = W'($urandom);
      tick();
      if (!valid_o || ready_o || quotient_o !== q || remainder_o !== r ||
          div_by_zero_o !== dz || overflow_o !== ov) stable_bad = 1'b1;
    end
    valid_i = 1'b0;
    chk("hold_stable", stable_bad, 0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("idle_after_hs", {ready_o, valid_o}, 2'b10);
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er;
    logic         dz, ov, edz, eov, sgn, sawv;
    logic [W-1:0] n, d;
    int           lat, sel;

    tbl[0]  = '{1'b0, 16'd1000, 16'd7,  16'd142,  16'd6,    1'b0, 1'b0, 17, 10};
    tbl[1]  = '{1'b1, 16'hFFF9, 16'd2,  16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17, 0};
    tbl[2]  = '{1'b1, 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,  1'b0, 1'b0, 17, 0};
    tbl[3]  = '{1'b1, 16'h8000, 16'd1,  16'h8000, 16'd0,    1'b0, 1'b0, 17, 0};
    tbl[4]  = '{1'b0, 16'd200,  16'd0,  16'hFFFF, 16'd200,  1'b1, 1'b0, 1,  3};
    tbl[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,  1'b0, 1'b1, 1,  2};
    tbl[6]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'd1,  16'd0,    1'b0, 1'b0, 17, 0};
    tbl[7]  = '{1'b0, 16'd5,    16'd9,  16'd0,    16'd5,    1'b0, 1'b0, 17, 0};
    tbl[8]  = '{1'b1, 16'h8000, 16'd0,  16'hFFFF, 16'h8000, 1'b1, 1'b0, 1,  0};
    tbl[9]  = '{1'b0, 16'h8000, 16'hFFFF, 16'd0,  16'h8000, 1'b0, 1'b0, 17, 0};
    tbl[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'd1,  16'd0,    1'b0, 1'b0, 17, 0};
    tbl[11] = '{1'b1, 16'h8000, 16'd2,  16'hC000, 16'd0,    1'b0, 1'b0, 17, 0};
    tbl[12] = '{1'b1, 16'h8001, 16'd10, 16'hF334, 16'hFFF9, 1'b0, 1'b0, 17, 0};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; signed_i = 1'b0;
    numerator_i = '0; denominator_i = '0;
    tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_quot", quotient_o, 0);
    chk("rst_rem", remainder_o, 0);
    chk("rst_flags", {div_by_zero_o, overflow_o}, 0);
    tick();
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].sgn, tbl[i].n, tbl[i].d, tbl[i].bp, q, r, dz, ov, lat);
      chk($sformatf("tbl%0d_quot", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_rem", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dbz", i), dz, tbl[i].dz);
      chk($sformatf("tbl%0d_ovf", i), ov, tbl[i].ov);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end

    // Reset after the fifth iteration of a 16-iteration divide.
    signed_i = 1'b0; numerator_i = 16'd40000; denominator_i = 16'd3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_quot", quotient_o, 0);
    chk("midrst_rem", remainder_o, 0);
    chk("midrst_flags", {div_by_zero_o, overflow_o}, 0);
    tick();
    rst_i = 1'b0;
    sawv = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (valid_o) sawv = 1'b1;
    end
    chk("midrst_no_valid", sawv, 0);
    txn(1'b0, 16'hFFFF, 16'd255, 0, q, r, dz, ov, lat);
    chk("postrst_quot", q, 16'd257);
    chk("postrst_rem", r, 16'd0);
    chk("postrst_lat", lat, 17);

    for (int i = 0; i < 1500; i++) begin
      sgn = 1'($urandom);
      n   = W'($urandom);
      d   = W'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0: d = '0;
        1: begin n = 16'h8000; d = '1; end
        2: d = W'($urandom_range(1, 15));
        3: d = -W'($urandom_range(1, 15));
        4: n = W'($urandom_range(0, 20));
        default: ;
      endcase
      ref_div(sgn, n, d, eq, er, edz, eov);
      txn(sgn, n, d, $urandom_range(0, 3), q, r, dz, ov, lat);
      chk("rnd_quot", q, eq);
      chk("rnd_rem", r, er);
      chk("rnd_dbz", dz, edz);
      chk("rnd_ovf", ov, eov);
      chk("rnd_lat", lat, (edz || eov) ? 1 : W + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
